// File: rtl/noc_injection_arbiter.sv
// Packet-level round-robin injection arbiter in front of one router port.
// A granted header locks the port to its source until the tail; one output register stage.
module noc_injection_arbiter #(
  parameter int unsigned NumRequesters                  = 4,
  parameter int unsigned NetworkIfFlitWidth             = 64,
  parameter int unsigned NetworkIfFlitTypeWidth         = 2,
  parameter int unsigned NetworkIfBroadcastWidth        = 1,
  parameter int unsigned NetworkIfVirtualChannelIdWidth = 1,
  parameter int unsigned PacketCounterWidth             = 16
) (
  input  logic                                                      clk_network_i,
  input  logic                                                      rst_network_ni,
  input  logic [NumRequesters-1:0]                                  s_valid_i,
  output logic [NumRequesters-1:0]                                  s_ready_o,
  input  logic [NumRequesters*NetworkIfFlitWidth-1:0]               s_flit_i,
  input  logic [NumRequesters*NetworkIfFlitTypeWidth-1:0]           s_flit_type_i,
  input  logic [NumRequesters*NetworkIfBroadcastWidth-1:0]          s_broadcast_i,
  input  logic [NumRequesters*NetworkIfVirtualChannelIdWidth-1:0]   s_virtual_channel_id_i,
  output logic                                                      network_valid_o,
  input  logic                                                      network_ready_i,
  output logic [NetworkIfFlitWidth-1:0]                             network_flit_o,
  output logic [NetworkIfFlitTypeWidth-1:0]                         network_flit_type_o,
  output logic [NetworkIfBroadcastWidth-1:0]                        network_broadcast_o,
  output logic [NetworkIfVirtualChannelIdWidth-1:0]                 network_virtual_channel_id_o,
  output logic [$clog2(NumRequesters)-1:0]                          owner_o,
  output logic                                                      locked_o,
  output logic                                                      protocol_error_o,
  output logic [PacketCounterWidth-1:0]                             packet_count_o
);

  localparam int unsigned N   = NumRequesters;
  localparam int unsigned FW  = NetworkIfFlitWidth;
  localparam int unsigned TW  = NetworkIfFlitTypeWidth;
  localparam int unsigned BW  = NetworkIfBroadcastWidth;
  localparam int unsigned VW  = NetworkIfVirtualChannelIdWidth;
  localparam int unsigned PCW = PacketCounterWidth;
  localparam int unsigned IW  = $clog2(NumRequesters);

  localparam logic [TW-1:0] TypeHeader   = TW'(2'd0);
  localparam logic [TW-1:0] TypeTail     = TW'(2'd2);
  localparam logic [TW-1:0] TypeHeadTail = TW'(2'd3);

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (idx == IW'(N - 1)) begin
      return '0;
    end else begin
      return idx + IW'(1);
    end
  endfunction

  function automatic logic is_head(input logic [TW-1:0] t);
    return (t == TypeHeader) || (t == TypeHeadTail);
  endfunction

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [PCW-1:0]    cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [FW-1:0]     flit_q, flit_d;
  logic [TW-1:0]     type_q, type_d;
  logic [BW-1:0]     bc_q, bc_d;
  logic [VW-1:0]     vc_q, vc_d;

  logic [N-1:0]      head_s;
  logic [N-1:0]      cand_s;
  logic [IW:0]       idx_s;
  logic              found_s;
  logic [IW-1:0]     winner_s;
  logic [IW-1:0]     sel_s;
  logic [TW-1:0]     sel_type_s;
  logic              out_free_s;
  logic [N-1:0]      ready_s;
  logic              accept_s;
  logic              err_idle_s;

  // Classify each source's current flit as a packet start or not.
  always_comb begin
    head_s = '0;
    for (int i = 0; i < N; i++) begin
      head_s[i] = is_head(s_flit_type_i[i*TW +: TW]);
    end
  end

  assign cand_s     = s_valid_i & head_s;
  assign err_idle_s = (state_q == StIdle) && ((s_valid_i & ~head_s) != '0);
  assign out_free_s = ~valid_q | network_ready_i;

  // Round-robin search: first header candidate at or after the pointer, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, rr_q} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(N)) begin
        idx_s = idx_s - (IW+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && cand_s[idx_s[IW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_s[IW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Same-cycle grant; a locked owner is offered the port whether or not it is valid.
  always_comb begin
    ready_s = '0;
    if (!rst_network_ni) begin
      ready_s = '0;
    end else if (state_q == StLocked) begin
      ready_s[owner_q] = out_free_s;
    end else if (found_s) begin
      ready_s[winner_s] = out_free_s;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s   = (ready_s & s_valid_i) != '0;
  assign sel_s      = (state_q == StLocked) ? owner_q : winner_s;
  assign sel_type_s = s_flit_type_i[sel_s*TW +: TW];

  // Next-state for the packet FSM, counters and the output register.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q | err_idle_s;
    valid_d = valid_q;
    flit_d  = flit_q;
    type_d  = type_q;
    bc_d    = bc_q;
    vc_d    = vc_q;
    if (out_free_s) begin
      valid_d = accept_s;
      if (accept_s) begin
        flit_d = s_flit_i[sel_s*FW +: FW];
        type_d = sel_type_s;
        bc_d   = s_broadcast_i[sel_s*BW +: BW];
        vc_d   = s_virtual_channel_id_i[sel_s*VW +: VW];
      end else begin
        flit_d = flit_q;
      end
    end else begin
      valid_d = valid_q;
    end
    if (accept_s) begin
      case (state_q)
        StIdle: begin
          owner_d = sel_s;
          if (sel_type_s == TypeHeader) begin
            state_d = StLocked;
          end else begin
            rr_d  = next_idx(sel_s);
            cnt_d = cnt_q + PCW'(1);
          end
        end
        StLocked: begin
          if (sel_type_s == TypeTail) begin
            state_d = StIdle;
            rr_d    = next_idx(owner_q);
            cnt_d   = cnt_q + PCW'(1);
          end else if (is_head(sel_type_s)) begin
            err_d = 1'b1;
          end else begin
            state_d = StLocked;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      flit_q  <= '0;
      type_q  <= '0;
      bc_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      type_q  <= type_d;
      bc_q    <= bc_d;
      vc_q    <= vc_d;
    end
  end

  assign s_ready_o                    = ready_s;
  assign network_valid_o              = valid_q;
  assign network_flit_o               = flit_q;
  assign network_flit_type_o          = type_q;
  assign network_broadcast_o          = bc_q;
  assign network_virtual_channel_id_o = vc_q;
  assign owner_o                      = owner_q;
  assign locked_o                     = (state_q == StLocked);
  assign protocol_error_o             = err_q;
  assign packet_count_o               = cnt_q;

endmodule
